// File: rtl/samples_to_som_axil_slave.sv
// samples_to_som_axil_slave: AXI4-Lite slave holding the four Samples_to_SOM control/status words.
// Define SAMPLES_TO_SOM_ADDR_DECODE_EN to answer word indices >= 4 with SLVERR instead of aliasing.
module samples_to_som_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3
);
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;
   logic                          aw_held, w_held, aw_fire, w_fire, ar_fire, commit, w_bad, r_bad;
   logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr, c_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data, c_data;
   logic [SW-1:0]                 w_strb, c_strb;
   logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
   logic                          unused_ok;
   assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID;
   assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID;
   assign S_AXI_ARREADY = !S_AXI_RVALID;
   assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
   // a slot that is already held wins over the live bus, which is idle for that channel anyway
   assign c_addr = aw_held ? aw_addr : S_AXI_AWADDR;
   assign c_data = w_held ? w_data : S_AXI_WDATA;
   assign c_strb = w_held ? w_strb : S_AXI_WSTRB;
   assign commit = (aw_held || aw_fire) && (w_held || w_fire) && !S_AXI_BVALID;
`ifdef SAMPLES_TO_SOM_ADDR_DECODE_EN
   assign w_bad = |c_addr[C_S_AXI_ADDR_WIDTH-1:4];
   assign r_bad = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
`else
   assign w_bad = 1'b0;
   assign r_bad = 1'b0;
`endif
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, c_addr[C_S_AXI_ADDR_WIDTH-1:4], c_addr[1:0],
                        S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0]};
   assign slv_reg0 = regs[0];
   assign slv_reg1 = regs[1];
   assign slv_reg2 = regs[2];
   assign slv_reg3 = regs[3];
   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_addr      <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= 2'b00;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RRESP  <= 2'b00;
         S_AXI_RDATA  <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end else begin
            if (aw_fire) begin
               aw_held <= 1'b1;
               aw_addr <= S_AXI_AWADDR;
            end
            if (w_fire) begin
               w_held <= 1'b1;
               w_data <= S_AXI_WDATA;
               w_strb <= S_AXI_WSTRB;
            end
         end
         if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= w_bad ? 2'b10 : 2'b00;
         end else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
         if (commit && !w_bad)
            for (int b = 0; b < SW; b++)
               if (c_strb[b]) regs[c_addr[3:2]][8*b +: 8] <= c_data[8*b +: 8];
         // nonblocking read of regs gives the pre-write value on a same-cycle collision
         if (ar_fire) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= r_bad ? '0 : regs[S_AXI_ARADDR[3:2]];
            S_AXI_RRESP  <= r_bad ? 2'b10 : 2'b00;
         end else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      end
endmodule
